// File: rtl/pcpu_pkg.sv
// Shared CPU-side definitions: MIO peripheral addresses and UART transmitter types.
package pcpu;

    localparam logic [31:0] UART_BASE = 32'hD000_0000;

    // Register index taken from addr[3:2]
    localparam logic [1:0] UART_DATA = 2'd0;
    localparam logic [1:0] UART_STAT = 2'd1;
    localparam logic [1:0] UART_DIV  = 2'd2;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } uart_tx_state_t;

    typedef struct packed {
        logic irq;
        logic ovf;
        logic busy;
        logic full;
        logic empty;
    } uart_status_t;

    // A divisor of zero would stall the bit timer, so it behaves as one clock per bit.
    function automatic logic [15:0] uart_eff_div(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction

endpackage

// File: rtl/mio_uart_tx_fifo.sv
// Synchronous FIFO with pointer+count bookkeeping; a push while full is accepted only
// when a pop happens on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mio_uart_tx.sv
// MIO-bus UART transmitter: DATA/STATUS/BAUDDIV registers, 8-deep TX FIFO and an
// 8N1 serializer whose bit timer is reloaded from a divisor latched at frame start.
module mio_uart_tx
    import pcpu::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int DEFAULT_DIV = 868
) (
    input  logic        clk,
    input  logic        RSTN,
    input  logic        sel,
    input  logic        mem_w,
    input  logic [31:0] addr_bus,
    input  logic [31:0] Cpu_data2bus,
    output logic [31:0] bus_rdata,
    output logic        txd,
    output logic        tx_irq
);

    uart_tx_state_t r_state;
    uart_tx_state_t w_state_next;
    uart_status_t   w_status;
    logic [15:0]    r_div;
    logic [15:0]    r_cur_div;
    logic [15:0]    r_timer;
    logic [15:0]    w_div_eff;
    logic [2:0]     r_bit_idx;
    logic [7:0]     r_shift;
    logic [7:0]     w_fifo_rdata;
    logic [1:0]     w_reg_idx;
    logic           r_txd;
    logic           r_ovf;
    logic           r_irq;
    logic           w_fifo_full;
    logic           w_fifo_empty;
    logic           w_pop;
    logic           w_tick;
    logic           w_wr_data;
    logic           w_wr_stat;
    logic           w_wr_div;
    logic           w_drop;
    logic           w_unused;

    assign w_reg_idx = addr_bus[3:2];
    assign w_wr_data = sel & mem_w & (w_reg_idx == UART_DATA);
    assign w_wr_stat = sel & mem_w & (w_reg_idx == UART_STAT);
    assign w_wr_div  = sel & mem_w & (w_reg_idx == UART_DIV);
    assign w_drop    = w_wr_data & w_fifo_full & ~w_pop;
    assign w_tick    = (r_timer == 16'd0);
    assign w_div_eff = uart_eff_div(r_div);
    assign w_unused  = ^{addr_bus[31:4], addr_bus[1:0], Cpu_data2bus[31:16]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (RSTN),
        .i_push  (w_wr_data),
        .i_pop   (w_pop),
        .i_wdata (Cpu_data2bus[7:0]),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) r_state <= TX_IDLE;
        else       r_state <= w_state_next;
    end

    // STOP pops straight into START so queued frames run with no idle gap.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            TX_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = TX_START;
                end
            end
            TX_START: if (w_tick) w_state_next = TX_DATA;
            TX_DATA:  if (w_tick && r_bit_idx == 3'd7) w_state_next = TX_STOP;
            TX_STOP: begin
                if (w_tick) begin
                    if (!w_fifo_empty) begin
                        w_pop        = 1'b1;
                        w_state_next = TX_START;
                    end else begin
                        w_state_next = TX_IDLE;
                    end
                end
            end
            default: w_state_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            r_timer   <= '0;
            r_cur_div <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_txd     <= 1'b1;
        end else if (w_pop) begin
            r_shift   <= w_fifo_rdata;
            r_cur_div <= w_div_eff;
            r_timer   <= w_div_eff - 16'd1;
            r_bit_idx <= '0;
            r_txd     <= 1'b0;
        end else if (r_state != TX_IDLE) begin
            if (w_tick) begin
                r_timer <= r_cur_div - 16'd1;
                case (r_state)
                    TX_START: r_txd <= r_shift[0];
                    TX_DATA: begin
                        if (r_bit_idx == 3'd7) begin
                            r_txd <= 1'b1;
                        end else begin
                            r_txd     <= r_shift[1];
                            r_shift   <= r_shift >> 1;
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                    default: r_txd <= 1'b1;
                endcase
            end else begin
                r_timer <= r_timer - 16'd1;
            end
        end
    end

    // A dropped push sets ovf even if a clear were somehow presented on the same edge.
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            r_div <= 16'(DEFAULT_DIV);
            r_ovf <= 1'b0;
            r_irq <= 1'b1;
        end else begin
            if (w_wr_div) r_div <= Cpu_data2bus[15:0];
            if (w_drop)                              r_ovf <= 1'b1;
            else if (w_wr_stat && Cpu_data2bus[3])   r_ovf <= 1'b0;
            r_irq <= (r_state == TX_IDLE) & w_fifo_empty;
        end
    end

    assign txd    = r_txd;
    assign tx_irq = r_irq;

    always_comb begin
        w_status.irq   = r_irq;
        w_status.ovf   = r_ovf;
        w_status.busy  = (r_state != TX_IDLE);
        w_status.full  = w_fifo_full;
        w_status.empty = w_fifo_empty;
    end

    always_comb begin
        bus_rdata = '0;
        if (sel) begin
            case (w_reg_idx)
                UART_STAT: bus_rdata = {27'b0, w_status};
                UART_DIV:  bus_rdata = {16'b0, r_div};
                default:   bus_rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mio_uart_tx.sv
// Bench for mio_uart_tx: drives the MIO bus, records txd every clock and compares the
// recorded stream against an 8N1 waveform built from the bytes and divisors sent.
module tb_mio_uart_tx;
    import pcpu::*;

    localparam logic [31:0] A_DATA = UART_BASE + 32'h0;
    localparam logic [31:0] A_STAT = UART_BASE + 32'h4;
    localparam logic [31:0] A_DIV  = UART_BASE + 32'h8;
    localparam logic [31:0] A_RSVD = UART_BASE + 32'hC;

    logic        clk = 1'b0;
    logic        RSTN = 1'b0;
    logic        sel = 1'b0;
    logic        mem_w = 1'b0;
    logic [31:0] addr_bus = '0;
    logic [31:0] Cpu_data2bus = '0;
    logic [31:0] bus_rdata;
    logic        txd;
    logic        tx_irq;

    int checks = 0;
    int failures = 0;

    bit          rec = 1'b0;
    logic        trace[$];
    logic [0:0]  exp_q[$];
    logic [7:0]  byte_q[$];
    int          div_q[$];

    mio_uart_tx #(
        .FIFO_DEPTH  (8),
        .DEFAULT_DIV (868)
    ) dut (
        .clk          (clk),
        .RSTN         (RSTN),
        .sel          (sel),
        .mem_w        (mem_w),
        .addr_bus     (addr_bus),
        .Cpu_data2bus (Cpu_data2bus),
        .bus_rdata    (bus_rdata),
        .txd          (txd),
        .tx_irq       (tx_irq)
    );

    // clock / reset block
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (rec) trace.push_back(txd);
    end

    // driver tasks: called just after a falling edge, return just after the next one
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        sel = 1'b1; mem_w = 1'b1; addr_bus = a; Cpu_data2bus = d;
        @(negedge clk);
        sel = 1'b0; mem_w = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        sel = 1'b1; mem_w = 1'b0; addr_bus = a;
        #1;
        d = bus_rdata;
        @(negedge clk);
        sel = 1'b0;
    endtask

    task automatic check_reg(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] got;
        bus_read(a, got);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", name, got, exp);
        end
    endtask

    // scoreboard: trace index 0 is txd just after the first capture-window write edge
    task automatic start_capture();
        trace.delete();
        byte_q.delete();
        div_q.delete();
        rec = 1'b1;
    endtask

    task automatic add_frame(input logic [7:0] b, input int div);
        byte_q.push_back(b);
        div_q.push_back(div);
    endtask

    task automatic check_stream(input string name, input int tail);
        int eff;
        int budget;
        int bad;
        exp_q.delete();
        exp_q.push_back(1'b1);
        foreach (byte_q[f]) begin
            eff = (div_q[f] == 0) ? 1 : div_q[f];
            repeat (eff) exp_q.push_back(1'b0);
            for (int b = 0; b < 8; b++) repeat (eff) exp_q.push_back(byte_q[f][b]);
            repeat (eff) exp_q.push_back(1'b1);
        end
        repeat (tail) exp_q.push_back(1'b1);
        budget = exp_q.size() + 50;
        while (trace.size() < exp_q.size() && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        rec = 1'b0;
        checks++;
        if (trace.size() < exp_q.size()) begin
            failures++;
            $display("FAIL %s timeout samples=%0d exp=%0d", name, trace.size(), exp_q.size());
        end else begin
            bad = -1;
            for (int i = 0; i < exp_q.size(); i++) begin
                if (bad < 0 && trace[i] !== exp_q[i]) bad = i;
            end
            if (bad >= 0) begin
                failures++;
                $display("FAIL %s txd at sample %0d got=%b exp=%b", name, bad, trace[bad], exp_q[bad]);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (txd !== 1'b1 || tx_irq !== 1'b1) begin
            failures++;
            $display("FAIL reset_outputs got txd=%b irq=%b exp txd=1 irq=1", txd, tx_irq);
        end
        RSTN = 1'b1;
        @(negedge clk);
        check_reg("reset_status", A_STAT, 32'h11);
        check_reg("reset_div", A_DIV, 32'd868);
        check_reg("data_reads_zero", A_DATA, 32'h0);
        bus_write(A_RSVD, 32'hFFFF_FFFF);
        check_reg("reserved_reads_zero", A_RSVD, 32'h0);
        check_reg("reserved_write_ignored", A_DIV, 32'd868);
        addr_bus = A_DIV;
        #1;
        checks++;
        if (bus_rdata !== 32'h0) begin
            failures++;
            $display("FAIL rdata_unselected got=0x%08h exp=0x00000000", bus_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_single();
        bus_write(A_DIV, 32'd4);
        start_capture();
        bus_write(A_DATA, 32'h55);
        add_frame(8'h55, 4);
        repeat (3) @(negedge clk);
        checks++;
        if (tx_irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_during_frame got=%b exp=0", tx_irq);
        end
        check_reg("status_mid_frame", A_STAT, 32'h05);
        check_stream("frame_0x55", 4);
        repeat (2) @(negedge clk);
        checks++;
        if (tx_irq !== 1'b1) begin
            failures++;
            $display("FAIL irq_after_frame got=%b exp=1", tx_irq);
        end
    endtask

    task automatic test_back_to_back();
        bus_write(A_DIV, 32'd2);
        start_capture();
        for (int i = 0; i < 9; i++) begin
            bus_write(A_DATA, 32'(i));
            add_frame(8'(i), 2);
        end
        check_reg("status_nine_accepted", A_STAT, 32'h06);
        check_stream("nine_back_to_back", 4);
        check_reg("status_after_nine", A_STAT, 32'h11);
    endtask

    task automatic test_overflow();
        logic [7:0] b;
        bus_write(A_DIV, 32'd868);
        start_capture();
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom_range(0, 255));
            bus_write(A_DATA, {24'hABCDEF, b});
            if (i < 9) add_frame(b, (i == 0) ? 868 : 3);
        end
        check_reg("status_overflow", A_STAT, 32'h0E);
        bus_write(A_STAT, 32'h0000_00FF);
        check_reg("status_ovf_cleared", A_STAT, 32'h06);
        bus_write(A_DIV, 32'd3);
        check_stream("overflow_nine_frames", 40);
        check_reg("status_after_overflow", A_STAT, 32'h11);
    endtask

    task automatic test_baud_change();
        logic [7:0] a;
        logic [7:0] b;
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
        bus_write(A_DIV, 32'd4);
        start_capture();
        bus_write(A_DATA, {24'h0, a});
        add_frame(a, 4);
        repeat (8) @(negedge clk);
        bus_write(A_DIV, 32'hFFFF_0008);
        bus_write(A_DATA, {24'h0, b});
        add_frame(b, 8);
        check_reg("div_readback_8", A_DIV, 32'd8);
        check_stream("retime_next_frame", 4);
    endtask

    task automatic test_div_zero();
        bus_write(A_DIV, 32'd0);
        check_reg("div_readback_0", A_DIV, 32'd0);
        start_capture();
        bus_write(A_DATA, 32'hA3);
        add_frame(8'hA3, 0);
        check_stream("div_zero_0xA3", 4);
    endtask

    task automatic test_random();
        int div;
        int n;
        logic [7:0] b;
        for (int it = 0; it < 4; it++) begin
            div = $urandom_range(1, 6);
            n = $urandom_range(1, 4);
            bus_write(A_DIV, 32'(div));
            start_capture();
            for (int k = 0; k < n; k++) begin
                b = 8'($urandom_range(0, 255));
                bus_write(A_DATA, {24'h0, b});
                add_frame(b, div);
            end
            check_stream($sformatf("random_%0d_div%0d_n%0d", it, div, n), 4);
            check_reg($sformatf("random_%0d_status", it), A_STAT, 32'h11);
        end
    endtask

    task automatic test_reset_mid_frame();
        bus_write(A_DIV, 32'd4);
        bus_write(A_DATA, 32'hF7);
        bus_write(A_DATA, 32'h3C);
        bus_write(A_DATA, 32'h81);
        repeat (16) @(negedge clk);
        checks++;
        if (txd !== 1'b0) begin
            failures++;
            $display("FAIL bit3_before_reset got=%b exp=0", txd);
        end
        #2;
        RSTN = 1'b0;
        #1;
        checks++;
        if (txd !== 1'b1) begin
            failures++;
            $display("FAIL txd_async_reset got=%b exp=1", txd);
        end
        @(negedge clk);
        @(negedge clk);
        RSTN = 1'b1;
        @(negedge clk);
        check_reg("status_after_abort", A_STAT, 32'h11);
        check_reg("div_after_abort", A_DIV, 32'd868);
        start_capture();
        check_stream("no_frames_after_abort", 100);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_baud_change();
        test_div_zero();
        test_random();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
